dp_operand_loader: RTL and testbench

Upstream operand staging stage for the combinational four-term dot-product core. It accepts one (x, y) operand pair per cycle over a valid/ready stream and assembles four pairs into a group. Groups are held in a two-bank ping-pong buffer and presented as stable x1..x4 / y1..y4 words. In half mode it zero-extends operands so the core's mode detection (x1[31:16] all zero means half) is correct.

---
 rtl/dp_operand_loader.sv | 126 ++++++++++++
 tb/tb_dp_operand_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dp_operand_loader.sv
// Operand staging for the four-term dot-product core: collects four (x, y) pairs
// per group into a two-bank ping-pong buffer and presents each full group as stable words.
module dp_operand_loader #(
  parameter int unsigned DEPTH_BANKS = 2,
  parameter int unsigned PAIRS       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x1,
  output logic [31:0] out_x2,
  output logic [31:0] out_x3,
  output logic [31:0] out_x4,
  output logic [31:0] out_y1,
  output logic [31:0] out_y2,
  output logic [31:0] out_y3,
  output logic [31:0] out_y4,
  output logic        out_mode,
  output logic        mode_err,
  output logic        alias_err
);

  localparam int unsigned SW = $clog2(PAIRS);
  localparam int unsigned BW = $clog2(DEPTH_BANKS);
  localparam int unsigned CW = $clog2(DEPTH_BANKS + 1);

  logic [31:0]            x_mem [DEPTH_BANKS][PAIRS];
  logic [31:0]            y_mem [DEPTH_BANKS][PAIRS];
  logic [DEPTH_BANKS-1:0] bank_full;
  logic [DEPTH_BANKS-1:0] bank_mode;
  logic [BW-1:0]          wr_bank;
  logic [BW-1:0]          rd_bank;
  logic [SW-1:0]          pair_cnt;
  logic [CW-1:0]          full_cnt;

  logic        accept;
  logic        last_slot;
  logic        complete;
  logic        deliver;
  logic        eff_mode;
  logic        presenting;
  logic [31:0] st_x;
  logic [31:0] st_y;

  always_comb begin
    in_ready   = (full_cnt != CW'(DEPTH_BANKS));
    out_valid  = (full_cnt != '0);
    accept     = in_valid && in_ready;
    last_slot  = (pair_cnt == SW'(PAIRS - 1));
    complete   = accept && last_slot;
    deliver    = out_valid && out_ready;
    // Slot 0 defines the group mode; later pairs are coerced to it.
    eff_mode   = (pair_cnt == '0) ? in_mode : bank_mode[wr_bank];
    st_x       = eff_mode ? {16'h0000, in_x[15:0]} : in_x;
    st_y       = eff_mode ? {16'h0000, in_y[15:0]} : in_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < DEPTH_BANKS; b++) begin
        for (int unsigned p = 0; p < PAIRS; p++) begin
          x_mem[b][p] <= '0;
          y_mem[b][p] <= '0;
        end
      end
      bank_full <= '0;
      bank_mode <= '0;
      wr_bank   <= '0;
      rd_bank   <= '0;
      pair_cnt  <= '0;
      full_cnt  <= '0;
      mode_err  <= 1'b0;
      alias_err <= 1'b0;
    end else begin
      if (accept) begin
        x_mem[wr_bank][pair_cnt] <= st_x;
        y_mem[wr_bank][pair_cnt] <= st_y;
        if (pair_cnt == '0) begin
          bank_mode[wr_bank] <= in_mode;
        end else if (in_mode != bank_mode[wr_bank]) begin
          mode_err <= 1'b1;
        end
        if (last_slot) begin
          bank_full[wr_bank] <= 1'b1;
          wr_bank            <= wr_bank + 1'b1;
          pair_cnt           <= '0;
          if (!eff_mode && x_mem[wr_bank][0][31:16] == 16'h0000) begin
            alias_err <= 1'b1;
          end
        end else begin
          pair_cnt <= pair_cnt + 1'b1;
        end
      end
      // The fill bank is never the presented full bank, so these never collide.
      if (deliver) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= rd_bank + 1'b1;
      end
      case ({complete, deliver})
        2'b10:   full_cnt <= full_cnt + 1'b1;
        2'b01:   full_cnt <= full_cnt - 1'b1;
        default: full_cnt <= full_cnt;
      endcase
    end
  end

  always_comb begin
    presenting = bank_full[rd_bank];
    out_x1     = presenting ? x_mem[rd_bank][0] : '0;
    out_x2     = presenting ? x_mem[rd_bank][1] : '0;
    out_x3     = presenting ? x_mem[rd_bank][2] : '0;
    out_x4     = presenting ? x_mem[rd_bank][3] : '0;
    out_y1     = presenting ? y_mem[rd_bank][0] : '0;
    out_y2     = presenting ? y_mem[rd_bank][1] : '0;
    out_y3     = presenting ? y_mem[rd_bank][2] : '0;
    out_y4     = presenting ? y_mem[rd_bank][3] : '0;
    out_mode   = presenting ? bank_mode[rd_bank] : 1'b0;
  end

endmodule

// File: tb/tb_dp_operand_loader.sv
// Scoreboard bench for dp_operand_loader: groups are predicted from accepted pairs
// and compared by a monitor whenever a group is presented.
module tb_dp_operand_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_x1, out_x2, out_x3, out_x4;
  logic [31:0] out_y1, out_y2, out_y3, out_y4;
  logic        out_mode;
  logic        mode_err;
  logic        alias_err;

  always #5 clk = ~clk;

  dp_operand_loader #(.DEPTH_BANKS(2), .PAIRS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x1(out_x1), .out_x2(out_x2), .out_x3(out_x3), .out_x4(out_x4),
    .out_y1(out_y1), .out_y2(out_y2), .out_y3(out_y3), .out_y4(out_y4),
    .out_mode(out_mode), .mode_err(mode_err), .alias_err(alias_err)
  );

  typedef struct packed {
    logic         mode;
    logic [255:0] w;   // {x1..x4, y1..y4}
  } grp_t;

  grp_t        exp_q[$];
  logic [31:0] part_x[$];
  logic [31:0] part_y[$];
  logic        part_mode;
  logic        exp_mode_err;
  logic        exp_alias_err;
  logic        rand_rdy;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [256:0] got, input logic [256:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void model_accept(input logic m, input logic [31:0] x, input logic [31:0] y);
    grp_t g;
    if (part_x.size() == 0) part_mode = m;
    else if (m != part_mode) exp_mode_err = 1'b1;
    part_x.push_back(part_mode ? {16'h0000, x[15:0]} : x);
    part_y.push_back(part_mode ? {16'h0000, y[15:0]} : y);
    if (part_x.size() == 4) begin
      g.mode = part_mode;
      g.w = {part_x[0], part_x[1], part_x[2], part_x[3],
             part_y[0], part_y[1], part_y[2], part_y[3]};
      exp_q.push_back(g);
      if (!part_mode && part_x[0][31:16] == 16'h0000) exp_alias_err = 1'b1;
      part_x.delete();
      part_y.delete();
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    part_x.delete();
    part_y.delete();
    exp_mode_err  = 1'b0;
    exp_alias_err = 1'b0;
  endfunction

  // Monitor: flow-control and flag expectations derive from the count of pending groups.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("out_valid", out_valid, exp_q.size() != 0);
        check("in_ready", in_ready, exp_q.size() < 2);
        check("mode_err", mode_err, exp_mode_err);
        check("alias_err", alias_err, exp_alias_err);
        if (out_valid && exp_q.size() != 0) begin
          check("group", {out_mode, out_x1, out_x2, out_x3, out_x4,
                          out_y1, out_y2, out_y3, out_y4}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic m, input logic [31:0] x, input logic [31:0] y,
                      input int unsigned max_wait, output logic acc);
    in_valid = 1'b1;
    in_mode  = m;
    in_x     = x;
    in_y     = y;
    acc      = 1'b0;
    for (int unsigned c = 0; c < max_wait && !acc; c++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      @(posedge clk);
      if (acc) model_accept(m, x, y);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_req(input logic m, input logic [31:0] x, input logic [31:0] y);
    logic acc;
    send(m, x, y, 50, acc);
    check("accept_timeout", acc, 1'b1);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  logic [31:0] xs [4];
  logic [31:0] rx;
  logic        acc;
  logic        gm;
  int          acc_cnt;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_x = '0; in_y = '0;
    out_ready = 1'b0; rand_rdy = 1'b0;
    model_reset();
    idle(1);
    do_reset();
    check("reset_outputs", {out_mode, out_x1, out_x2, out_x3, out_x4,
                            out_y1, out_y2, out_y3, out_y4}, '0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);

    // Single-mode directed group
    xs[0] = 32'h3F800000; xs[1] = 32'h40000000; xs[2] = 32'h40400000; xs[3] = 32'h40800000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_req(1'b0, xs[i], 32'h3F800000);
    idle(3);

    // Half-mode directed group
    for (int i = 0; i < 4; i++) send_req(1'b1, 32'hDEAD3C00, 32'hBEEF4000);
    idle(3);

    // Backpressure: only two groups fit
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      send(1'b0, 32'h80000000 | $urandom, $urandom, 3, acc);
      if (acc) acc_cnt++;
    end
    check("bp_accepted", acc_cnt, 8);
    check("bp_in_ready_low", in_ready, 1'b0);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("bp_in_ready_back", in_ready, 1'b1);
    idle(2);
    out_ready = 1'b1;
    idle(3);

    // Completion of group 2 coincides with transfer of group 1
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_req(1'b0, 32'h40000000 + i, 32'h3F000000 + i);
    out_ready = 1'b1;
    send_req(1'b0, 32'h40000007, 32'h3F000007);
    out_ready = 1'b0;
    idle(2);
    out_ready = 1'b1;
    idle(3);

    // Randomized groups with random backpressure
    rand_rdy = 1'b1;
    for (int g = 0; g < 60; g++) begin
      gm = $urandom_range(0, 1);
      for (int i = 0; i < 4; i++) begin
        rx = $urandom;
        if (!gm && i == 0) rx[31] = 1'b1;
        send_req(gm, rx, $urandom);
        if ($urandom_range(0, 7) == 0) idle(1);
      end
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Sticky error flags
    send_req(1'b1, 32'hDEAD3C00, 32'hBEEF4000);
    send_req(1'b1, 32'hDEAD3C00, 32'hBEEF4000);
    send_req(1'b0, 32'hDEAD3C00, 32'hBEEF4000);
    send_req(1'b1, 32'hDEAD3C00, 32'hBEEF4000);
    idle(1);
    check("mode_err_set", mode_err, 1'b1);
    send_req(1'b0, 32'h00001234, 32'h3F800000);
    for (int i = 0; i < 3; i++) send_req(1'b0, 32'h40000000, 32'h3F800000);
    idle(1);
    check("alias_err_set", alias_err, 1'b1);
    for (int i = 0; i < 4; i++) send_req(1'b0, 32'h41000000, 32'h3F800000);
    idle(3);
    check("flags_persist", {mode_err, alias_err}, 2'b11);

    // Reset with one full bank and a partial group
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_req(1'b0, 32'hC0000000 + i, 32'h3F800000);
    do_reset();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_flags", {mode_err, alias_err}, 2'b00);
    check("rst_outputs", {out_mode, out_x1, out_x2, out_x3, out_x4,
                          out_y1, out_y2, out_y3, out_y4}, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_req(1'b0, 32'h3F800000 + i, 32'h40000000 + i);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
